// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory-bus arbiter.
// Holds the FSM state encoding, default limits and the streak saturation helper.
package mem_arbiter_pkg;

  localparam int DATA_W           = 32;
  localparam int STREAK_W         = 3;
  localparam int WDOG_W           = 8;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 255;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BUSY_I = 3'd1,
    S_BUSY_D = 3'd2,
    S_DONE_I = 3'd3,
    S_DONE_D = 3'd4
  } state_t;

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v,
                                                  input logic [STREAK_W-1:0] lim);
    return (v >= lim) ? lim : v + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// Bus-transaction watchdog: counts busy cycles without an ack and flags expiry
// on the cycle whose increment would make the count reach TIMEOUT.
module arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + WDOG_W'(1);
  end

  assign o_expired = i_en && (r_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and data
// access: data-first priority, starvation override for fetches, hung-bus watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inst_ren,
  input  logic [DATA_W-1:0] i_inst_addr,
  output logic [DATA_W-1:0] o_inst_data,
  output logic              o_inst_ready,
  output logic              o_inst_stall,
  input  logic              i_mem_ren,
  input  logic              i_mem_wen,
  input  logic [DATA_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic [DATA_W-1:0] o_mem_din,
  output logic              o_mem_ready,
  output logic              o_mem_stall,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [DATA_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [DATA_W-1:0] i_bus_rdata,
  output logic              o_bus_err
);

  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STARVE_LIMIT);

  state_t              r_state, w_next;
  logic                r_bus_req, r_bus_we, r_bus_err;
  logic [DATA_W-1:0]   r_bus_addr, r_bus_wdata, r_inst_data, r_mem_din;
  logic [STREAK_W-1:0] r_streak;
  logic                w_data_req, w_grant_i, w_grant_d, w_busy;
  logic                w_ack, w_expired, w_finish;

  assign w_data_req = i_mem_ren | i_mem_wen;
  assign w_busy     = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
  assign w_ack      = w_busy & i_bus_ack;
  assign w_finish   = w_ack | w_expired;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_grant_i | w_grant_d),
    .i_en      (w_busy & ~i_bus_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // A waiting fetch overrides data only once the streak has saturated.
  always_comb begin
    w_next    = r_state;
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_data_req && !(i_inst_ren && (r_streak == STREAK_LIM))) begin
          w_grant_d = 1'b1;
          w_next    = S_BUSY_D;
        end else if (i_inst_ren) begin
          w_grant_i = 1'b1;
          w_next    = S_BUSY_I;
        end
      end
      S_BUSY_I: if (w_finish) w_next = S_DONE_I;
      S_BUSY_D: if (w_finish) w_next = S_DONE_D;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      if (w_grant_i || w_grant_d) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= w_grant_d & i_mem_wen;
        r_bus_addr  <= w_grant_d ? i_mem_addr : i_inst_addr;
        r_bus_wdata <= w_grant_d ? i_mem_dout : '0;
      end else if (w_finish) begin
        r_bus_req <= 1'b0;
      end
      if (w_expired) r_bus_err <= 1'b1;
    end
  end

  // Aborted transactions and completed writes return zero to the requester.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inst_data <= '0;
      r_mem_din   <= '0;
    end else begin
      if (w_finish && (r_state == S_BUSY_I))
        r_inst_data <= w_ack ? i_bus_rdata : '0;
      if (w_finish && (r_state == S_BUSY_D))
        r_mem_din <= (w_ack && !r_bus_we) ? i_bus_rdata : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                              r_streak <= '0;
    else if (w_grant_i)                        r_streak <= '0;
    else if ((r_state == S_IDLE) && !i_inst_ren) r_streak <= '0;
    else if (w_grant_d)                        r_streak <= sat_inc(r_streak, STREAK_LIM);
  end

  assign o_inst_ready = (r_state == S_DONE_I);
  assign o_mem_ready  = (r_state == S_DONE_D);
  assign o_inst_stall = i_inst_ren & ~o_inst_ready;
  assign o_mem_stall  = w_data_req & ~o_mem_ready;
  assign o_inst_data  = r_inst_data;
  assign o_mem_din    = r_mem_din;
  assign o_bus_req    = r_bus_req;
  assign o_bus_we     = r_bus_we;
  assign o_bus_addr   = r_bus_addr;
  assign o_bus_wdata  = r_bus_wdata;
  assign o_bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: expected grants and port data are
// queued when stimulus is applied and checked as the bus and ports respond.
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_ren, inst_ready, inst_stall;
  logic [31:0] inst_addr, inst_data;
  logic        mem_ren, mem_wen, mem_ready, mem_stall;
  logic [31:0] mem_addr, mem_dout, mem_din;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  grant_t      grant_q[$];
  logic [31:0] inst_q[$];
  logic [31:0] mem_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int n_inst = 0, n_mem = 0;
  int inst_ready_cyc = 0, mem_ready_cyc = 0;
  int ack_delay = -1;
  int bus_cyc = 0;
  int last_req_len = 0;
  logic        late_ack = 1'b0;
  logic        held_we = 1'b0;
  logic [31:0] held_addr = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_inst_ren  (inst_ren),
    .i_inst_addr (inst_addr),
    .o_inst_data (inst_data),
    .o_inst_ready(inst_ready),
    .o_inst_stall(inst_stall),
    .i_mem_ren   (mem_ren),
    .i_mem_wen   (mem_wen),
    .i_mem_addr  (mem_addr),
    .i_mem_dout  (mem_dout),
    .o_mem_din   (mem_din),
    .o_mem_ready (mem_ready),
    .o_mem_stall (mem_stall),
    .o_bus_req   (bus_req),
    .o_bus_we    (bus_we),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .i_bus_ack   (bus_ack),
    .i_bus_rdata (bus_rdata),
    .o_bus_err   (bus_err)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h100) return 32'h2402000A;
    return {a[15:0] ^ 16'hC3C3, ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_grant(input logic we, input logic [31:0] a, input logic [31:0] wd);
    grant_t g;
    g.we = we; g.addr = a; g.wdata = wd;
    grant_q.push_back(g);
  endtask

  // One clock: observe at the falling edge, answer the bus, return just after the rising edge.
  task automatic tick();
    grant_t g;
    @(negedge clk);
    chk("inst_stall", inst_stall, inst_ren & ~inst_ready);
    chk("mem_stall", mem_stall, (mem_ren | mem_wen) & ~mem_ready);
    if (inst_ready) begin
      chk("inst_ready_expected", 32'(inst_q.size() > 0), 32'd1);
      if (inst_q.size() > 0) chk("inst_data", inst_data, inst_q.pop_front());
      n_inst++;
      inst_ready_cyc = cyc;
    end
    if (mem_ready) begin
      chk("mem_ready_expected", 32'(mem_q.size() > 0), 32'd1);
      if (mem_q.size() > 0) chk("mem_din", mem_din, mem_q.pop_front());
      n_mem++;
      mem_ready_cyc = cyc;
    end
    if (bus_req) begin
      if (bus_cyc == 0) begin
        chk("grant_expected", 32'(grant_q.size() > 0), 32'd1);
        if (grant_q.size() > 0) begin
          g = grant_q.pop_front();
          chk("grant_we", bus_we, g.we);
          chk("grant_addr", bus_addr, g.addr);
          if (g.we) chk("grant_wdata", bus_wdata, g.wdata);
        end
        held_addr = bus_addr;
        held_we   = bus_we;
      end else begin
        chk("bus_addr_hold", bus_addr, held_addr);
        chk("bus_we_hold", bus_we, held_we);
      end
      bus_ack   = late_ack | ((ack_delay >= 0) && (bus_cyc == ack_delay));
      bus_rdata = rd_model(bus_addr);
      bus_cyc++;
    end else begin
      if (bus_cyc > 0) last_req_len = bus_cyc;
      bus_cyc   = 0;
      bus_ack   = late_ack;
      bus_rdata = 32'hDEAD_BEEF;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_inst(input int target, input int budget);
    for (int t = 0; t < budget && n_inst < target; t++) tick();
    chk("inst_done_in_time", 32'(n_inst >= target), 32'd1);
  endtask

  task automatic wait_mem(input int target, input int budget);
    for (int t = 0; t < budget && n_mem < target; t++) tick();
    chk("mem_done_in_time", 32'(n_mem >= target), 32'd1);
  endtask

  initial begin
    int c0, k, mb, ib, mem_at_fetch;
    inst_ren = 0; inst_addr = 0; mem_ren = 0; mem_wen = 0; mem_addr = 0; mem_dout = 0;
    bus_ack = 0; bus_rdata = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_inst_ready", inst_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_bus_err", bus_err, 0);
    rst_n = 1'b1;
    tick();

    // Single fetch, ack two cycles into the request
    ack_delay = 2;
    push_grant(1'b0, 32'h100, 32'h0);
    inst_q.push_back(32'h2402000A);
    inst_ren = 1; inst_addr = 32'h100; c0 = cyc;
    wait_inst(1, 40);
    chk("fetch_latency", 32'(inst_ready_cyc), 32'(c0 + 4));
    inst_ren = 0;
    tick();

    // Contention: write wins, fetch follows; minimum latency bus
    ack_delay = 0;
    push_grant(1'b1, 32'h200, 32'h55);
    push_grant(1'b0, 32'h104, 32'h0);
    mem_q.push_back(32'h0);
    inst_q.push_back(rd_model(32'h104));
    inst_ren = 1; inst_addr = 32'h104;
    mem_wen = 1; mem_addr = 32'h200; mem_dout = 32'h55; c0 = cyc;
    wait_mem(1, 40);
    mem_wen = 0;
    chk("write_latency", 32'(mem_ready_cyc), 32'(c0 + 2));
    wait_inst(2, 40);
    inst_ren = 0;
    chk("mem_before_inst", 32'(mem_ready_cyc < inst_ready_cyc), 32'd1);
    tick();

    // Starvation: fetch forced through after STARVE_LIMIT data grants
    ack_delay = 1;
    for (int j = 0; j < 4; j++) push_grant(1'b0, 32'h300 + 32'(4 * j), 32'h0);
    push_grant(1'b0, 32'h108, 32'h0);
    for (int j = 4; j < 6; j++) push_grant(1'b0, 32'h300 + 32'(4 * j), 32'h0);
    for (int j = 0; j < 6; j++) mem_q.push_back(rd_model(32'h300 + 32'(4 * j)));
    inst_q.push_back(rd_model(32'h108));
    mb = n_mem; ib = n_inst; k = 0; mem_at_fetch = -1;
    inst_ren = 1; inst_addr = 32'h108;
    mem_ren = 1; mem_addr = 32'h300;
    for (int t = 0; t < 300 && (k < 6 || inst_ren); t++) begin
      tick();
      if (inst_ren && n_inst > ib) begin
        inst_ren = 0;
        mem_at_fetch = n_mem - mb;
      end
      if (n_mem > mb + k) begin
        k++;
        if (k < 6) mem_addr = 32'h300 + 32'(4 * k);
        else       mem_ren = 0;
      end
    end
    chk("starve_reads_done", 32'(k), 32'd6);
    chk("starve_fetch_done", 32'(n_inst - ib), 32'd1);
    chk("starve_reads_before_fetch", 32'(mem_at_fetch), 32'(STARVE_LIMIT));
    tick();

    // Watchdog abort on a read that is never acknowledged
    ack_delay = -1;
    push_grant(1'b0, 32'h400, 32'h0);
    mem_q.push_back(32'h0);
    mem_ren = 1; mem_addr = 32'h400;
    wait_mem(n_mem + 1, 60);
    mem_ren = 0;
    chk("timeout_req_len", 32'(last_req_len), 32'(TIMEOUT));
    chk("timeout_bus_err", bus_err, 1);
    mb = n_mem;
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    tick(); tick();
    chk("late_ack_bus_req", bus_req, 0);
    chk("late_ack_no_ready", 32'(n_mem - mb), 32'd0);
    chk("late_ack_bus_err", bus_err, 1);

    // Reset in the middle of a fetch
    push_grant(1'b0, 32'h500, 32'h0);
    inst_ren = 1; inst_addr = 32'h500;
    tick(); tick(); tick();
    chk("pre_rst_bus_req", bus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_bus_req", bus_req, 0);
    chk("midrst_bus_err", bus_err, 0);
    chk("midrst_inst_ready", inst_ready, 0);
    chk("midrst_bus_addr", bus_addr, 0);
    inst_addr = 32'h504;
    ack_delay = 1;
    push_grant(1'b0, 32'h504, 32'h0);
    inst_q.push_back(rd_model(32'h504));
    tick();
    rst_n = 1'b1;
    wait_inst(n_inst + 1, 40);
    inst_ren = 0;
    tick(); tick();

    chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
    chk("inst_q_drained", 32'(inst_q.size()), 32'd0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
